perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 162 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of tick-driven cycle counters; each channel stops when the core reads a chosen register/value.
// Define PERF_SNAPSHOT_EN to build per-channel snapshot shadows behind the read port.
module perf_counter_bank #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DIV_LOG2 = 1,
  parameter int unsigned LED_LSB  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ind_rs1,
  input  logic [31:0]       ind_data1,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [4:0]        cfg_reg,
  input  logic [31:0]       cfg_val,
  input  logic              start,
  input  logic              snap,
  input  logic [2:0]        rd_ch,
  input  logic              rd_shadow,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_ovf,
  output logic [NUM_CH-1:0] done,
  output logic [2:0]        LED_clk
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Low DIV_LOG2 prescaler bits; an all-zero mask makes every cycle a tick.
  localparam logic [31:0] TickMask = (32'd1 << DIV_LOG2) - 32'd1;

  logic [31:0]      presc_q;
  logic             tick;
  logic [NUM_CH-1:0] match;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] count_d [NUM_CH];
  logic [4:0]       mreg_q  [NUM_CH];
  logic [4:0]       mreg_d  [NUM_CH];
  logic [31:0]      mval_q  [NUM_CH];
  logic [31:0]      mval_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  assign tick    = ((presc_q & TickMask) == 32'd0);
  assign LED_clk = presc_q[LED_LSB+2:LED_LSB];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = (state_q[i] == StRun) && (mreg_q[i] != 5'd0) &&
                 (ind_rs1 == mreg_q[i]) && (ind_data1 == mval_q[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        count_q[i] <= '0;
        mreg_q[i]  <= '0;
        mval_q[i]  <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        mreg_q[i]  <= mreg_d[i];
        mval_q[i]  <= mval_d[i];
      end
    end
  end

  // Next state: a cfg write to the channel overrides start and match.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      mreg_d[i]  = mreg_q[i];
      mval_d[i]  = mval_q[i];
      if (cfg_we && (cfg_ch == 3'(i))) begin
        state_d[i] = StIdle;
        count_d[i] = '0;
        ovf_d[i]   = 1'b0;
        mreg_d[i]  = cfg_reg;
        mval_d[i]  = cfg_val;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (start) state_d[i] = StRun;
          end
          StRun: begin
            if (match[i]) begin
              state_d[i] = StDone;
            end else if (tick) begin
              count_d[i] = count_q[i] + CNT_W'(1);
              if (&count_q[i]) ovf_d[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      done[i] = (state_q[i] == StDone);
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [NUM_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= count_q[i];
    end
  end

  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) begin
        rd_count = rd_shadow ? shadow_q[i] : count_q[i];
        rd_ovf   = ovf_q[i];
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap ^ rd_shadow;

  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 3'(i)) begin
        rd_count = count_q[i];
        rd_ovf   = ovf_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: three instances cover divider, width and LED variants.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ind_rs1 = '0;
  logic [31:0] ind_data1 = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [4:0]  cfg_reg = '0;
  logic [31:0] cfg_val = '0;
  logic        start = 1'b0;
  logic        snap = 1'b0;
  logic [2:0]  rd_ch = '0;
  logic        rd_shadow = 1'b0;

  logic [31:0] rd_count_a, rd_count_b;
  logic [7:0]  rd_count_c;
  logic        rd_ovf_a, rd_ovf_b, rd_ovf_c;
  logic [3:0]  done_a, done_b, done_c;
  logic [2:0]  led_a, led_b, led_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .DIV_LOG2(0), .LED_LSB(2)) dut_a (
    .clk(clk), .rst(rst), .ind_rs1(ind_rs1), .ind_data1(ind_data1), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_val(cfg_val), .start(start), .snap(snap),
    .rd_ch(rd_ch), .rd_shadow(rd_shadow), .rd_count(rd_count_a), .rd_ovf(rd_ovf_a),
    .done(done_a), .LED_clk(led_a)
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .DIV_LOG2(2), .LED_LSB(12)) dut_b (
    .clk(clk), .rst(rst), .ind_rs1(ind_rs1), .ind_data1(ind_data1), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_val(cfg_val), .start(start), .snap(snap),
    .rd_ch(rd_ch), .rd_shadow(rd_shadow), .rd_count(rd_count_b), .rd_ovf(rd_ovf_b),
    .done(done_b), .LED_clk(led_b)
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .DIV_LOG2(0), .LED_LSB(12)) dut_c (
    .clk(clk), .rst(rst), .ind_rs1(ind_rs1), .ind_data1(ind_data1), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_val(cfg_val), .start(start), .snap(snap),
    .rd_ch(rd_ch), .rd_shadow(rd_shadow), .rd_count(rd_count_c), .rd_ovf(rd_ovf_c),
    .done(done_c), .LED_clk(led_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [4:0] r, input logic [31:0] v);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_reg = r;
    cfg_val = v;
    step(1);
    cfg_we  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_count", 64'(rd_count_a), 64'd0);
    chk("rst_ovf", 64'(rd_ovf_a), 64'd0);
    chk("rst_led", 64'(led_a), 64'd0);
    rst = 1'b1;
    step(13);
    chk("led_after_13", 64'(led_a), 64'd3);

    // Stop on match on the 100th cycle after start
    rd_ch = 3'd0;
    cfg_write(3'd0, 5'd31, 32'd400);
    pulse_start();
    chk("start_keeps_count", 64'(rd_count_a), 64'd0);
    step(99);
    chk("run_99", 64'(rd_count_a), 64'd99);
    chk("run_not_done", 64'(done_a[0]), 64'd0);
    ind_rs1 = 5'd31;
    ind_data1 = 32'd400;
    step(1);
    ind_rs1 = '0;
    ind_data1 = '0;
    chk("match_done", 64'(done_a[0]), 64'd1);
    chk("match_count", 64'(rd_count_a), 64'd99);
    step(50);
    chk("hold_count", 64'(rd_count_a), 64'd99);
    chk("hold_done", 64'(done_a), 64'b0001);

    // Divided tick, near-miss bus traffic
    rd_ch = 3'd1;
    cfg_write(3'd1, 5'd5, 32'd7);
    pulse_start();
    ind_rs1 = 5'd5;
    ind_data1 = 32'd8;
    step(40);
    ind_rs1 = '0;
    ind_data1 = '0;
    chk("div4_count", 64'(rd_count_b), 64'd10);
    chk("div4_not_done", 64'(done_b[1]), 64'd0);
    chk("div1_count", 64'(rd_count_a), 64'd40);

    // 8-bit wrap and sticky overflow, cleared by cfg write
    rd_ch = 3'd2;
    cfg_write(3'd2, 5'd0, 32'd0);
    pulse_start();
    step(300);
    chk("wrap_count", 64'(rd_count_c), 64'd44);
    chk("wrap_ovf", 64'(rd_ovf_c), 64'd1);
    chk("wrap_not_done", 64'(done_c[2]), 64'd0);
    cfg_write(3'd2, 5'd0, 32'd0);
    chk("cfg_clr_count", 64'(rd_count_c), 64'd0);
    chk("cfg_clr_ovf", 64'(rd_ovf_c), 64'd0);
    step(5);
    chk("cfg_idle", 64'(rd_count_c), 64'd0);

    // cfg write beats start and match in the same cycle
    cfg_write(3'd2, 5'd9, 32'd55);
    pulse_start();
    step(5);
    chk("pre_collide", 64'(rd_count_a), 64'd5);
    ind_rs1 = 5'd9;
    ind_data1 = 32'd55;
    start = 1'b1;
    cfg_write(3'd2, 5'd9, 32'd55);
    start = 1'b0;
    ind_rs1 = '0;
    ind_data1 = '0;
    chk("collide_done", 64'(done_a[2]), 64'd0);
    chk("collide_count", 64'(rd_count_a), 64'd0);
    step(3);
    chk("collide_idle", 64'(rd_count_a), 64'd0);

    // Matching bus in the start cycle is ignored in IDLE
    ind_rs1 = 5'd9;
    ind_data1 = 32'd55;
    pulse_start();
    ind_rs1 = '0;
    ind_data1 = '0;
    step(4);
    chk("idle_nomatch_count", 64'(rd_count_a), 64'd4);
    chk("idle_nomatch_done", 64'(done_a[2]), 64'd0);
    ind_rs1 = 5'd9;
    ind_data1 = 32'd55;
    step(1);
    ind_rs1 = '0;
    ind_data1 = '0;
    chk("late_match_done", 64'(done_a[2]), 64'd1);
    chk("late_match_count", 64'(rd_count_a), 64'd4);

    // Snapshot read port
    rd_ch = 3'd3;
    cfg_write(3'd3, 5'd0, 32'd0);
    pulse_start();
    step(20);
    chk("snap_pre", 64'(rd_count_a), 64'd20);
    snap = 1'b1;
    step(1);
    snap = 1'b0;
    step(9);
    chk("snap_live", 64'(rd_count_a), 64'd30);
    rd_shadow = 1'b1;
    #1;
`ifdef PERF_SNAPSHOT_EN
    chk("snap_shadow", 64'(rd_count_a), 64'd20);
`else
    chk("shadow_ignored", 64'(rd_count_a), 64'd30);
`endif
    rd_shadow = 1'b0;

    // Asynchronous reset mid-run
    chk("pre_rst_done", 64'(done_a), 64'b0101);
    #2;
    rst = 1'b0;
    #1;
    chk("async_done_a", 64'(done_a), 64'd0);
    chk("async_count_a", 64'(rd_count_a), 64'd0);
    chk("async_led_a", 64'(led_a), 64'd0);
    chk("async_done_b", 64'(done_b), 64'd0);
    chk("async_ovf_c", 64'(rd_ovf_c), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
